riscv_muldiv_issue_ctrl: RTL and testbench
==========================================

RISCV_MULDIV_ISSUE_CTRL -- requirements
Module: riscv_muldiv_issue_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-low.
REQ-002 Ports SHALL be as listed below, clock and reset first.
- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_val  in  1  decode stage presents an instruction
- req_rdy  out  1  controller can accept an instruction
- req_inst  in  32  RISC-V instruction message, standard field layout
- flush  in  1  squash any in-flight operation
- dp_divisor_zero  in  1  datapath flag: operand B == 0
- dp_load  out  1  datapath loads operands
- dp_step  out  1  datapath performs one iteration
- dp_fn  out  3  registered funct3 of the accepted op
- dp_signed_a  out  1  operand A is signed
- dp_signed_b  out  1  operand B is signed
- resp_val  out  1  result ready for writeback
- resp_rdy  in  1  writeback accepts the result
- resp_rd  out  5  destination register of the result
- illegal  out  1  one-cycle pulse: non-M-extension instruction was dropped
- busy  out  1  state != IDLE
- chk_rs1  in  5  source register 1 of the younger instruction
- chk_rs2  in  5  source register 2 of the younger instruction
- chk_hazard  out  1  RAW hazard against the in-flight rd

Function
REQ-003 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-004 req_rdy SHALL be (state==IDLE) && !flush.
REQ-005 An accept ("fire") SHALL occur when req_val && req_rdy.
REQ-006 A fire is an M-op when opcode==0110011 and funct7==0000001.
REQ-007 On an M-op fire:
- dp_load SHALL be 1 in the fire cycle (combinational).
- funct3 and rd SHALL be latched.
- The step counter SHALL clear to 0 and the state SHALL go to CALC.
REQ-008 On a non-M-op fire, the block SHALL pulse illegal for one cycle, SHALL discard the instruction and SHALL stay in IDLE.
REQ-009 In CALC, dp_step SHALL be 1 and the 6-bit counter SHALL increment each cycle. After the cycle with counter==31, the state SHALL go to DONE (32 steps).
REQ-010 Divide by zero: in the first CALC cycle (counter==0), if funct3[2]==1 and dp_divisor_zero==1:
- dp_step SHALL be 0 in that cycle.
- The state SHALL go directly to DONE.
REQ-011 In DONE, resp_val SHALL be 1 and resp_rd SHALL equal the latched rd.
REQ-012 The state SHALL go to IDLE in the cycle after resp_val && resp_rdy. There is no same-cycle re-accept.
REQ-013 Nominal latency: a fire at cycle T SHALL give resp_val at T+33. With divide by zero, resp_val SHALL be at T+2.
REQ-014 dp_fn SHALL equal the latched funct3.
REQ-015 dp_signed_a SHALL be 1 for MULH, MULHSU, DIV and REM.
REQ-016 dp_signed_b SHALL be 1 for MULH, DIV and REM.
REQ-017 flush SHALL have priority over all other events except reset:
- Any state SHALL go to IDLE on the next edge.
- resp_val SHALL be forced to 0 in the flush cycle.
- No response is ever issued for a flushed op.
REQ-018 chk_hazard SHALL equal busy && rd!=0 && (chk_rs1==rd || chk_rs2==rd), purely combinational.
REQ-019 resp_val held with resp_rdy=0 SHALL hold resp_val, resp_rd and dp_fn stable indefinitely.
REQ-020 The counter SHALL NOT wrap. It SHALL saturate by leaving CALC at 31.

Reset
REQ-021 While reset_n==0, all outputs SHALL be in their reset state:
- state=IDLE, counter=0.
- dp_fn=0, resp_rd=0.
- resp_val=0, dp_load=0, dp_step=0, illegal=0, busy=0, chk_hazard=0.
- req_rdy=0 while reset is asserted.
REQ-022 Reset assertion mid-operation SHALL abort without a response.

Structure
REQ-023 The shared package SHALL hold:
- OP opcode and MULDIV funct7 constants.
- The eight funct3 encodings (MUL to REMU).
- The FSM state encoding.
- The step count (32).
REQ-024 The field decode SHALL be one combinational sub-module, riscv_muldiv_decode, with outputs is_mop, is_div, signed_a and signed_b. The FSM and counter SHALL be in the top module.

Verification
REQ-025 MUL x5,x6,x7 (0x027302B3) fired at T, resp_rdy=1 -> dp_load at T; dp_step T+1..T+32; resp_val at T+33 with resp_rd=5; IDLE at T+34.
REQ-026 DIV x10,x11,x12 (0x02C5C533) with dp_divisor_zero=1 -> one CALC cycle with dp_step=0; resp_val at T+2 with resp_rd=10; dp_signed_a=dp_signed_b=1.
REQ-027 ADD x4,x0,x3 (0x00300233) -> illegal pulses once; busy stays 0; no resp_val.
REQ-028 MUL accepted, then flush at T+10 -> IDLE at T+11; resp_val never asserts; a new MUL is accepted at T+11.
REQ-029 MUL rd=5 in CALC: chk_rs2=5 -> chk_hazard=1; chk_rs1=chk_rs2=6 -> 0. An op with rd=0 never asserts chk_hazard.
REQ-030 resp_rdy=0 for 5 cycles in DONE -> resp_val and resp_rd hold; req_rdy=0 throughout; a reset_n pulse in DONE -> all outputs go to reset values immediately.

Source files
------------

// File: rtl/riscv_muldiv_issue_ctrl_pkg.sv
// Shared encodings for the M-extension issue controller: opcode/funct fields, FSM states, step count.
// Pure declarations, no logic; imported by the decode and top modules.
package riscv_muldiv_issue_ctrl_pkg;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam int STEP_COUNT = 32;
    localparam int CNT_W      = 6;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEP_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/riscv_muldiv_decode.sv
// Field decode of an R-type instruction into M-extension class and operand signedness.
// Combinational, zero latency; no flow control.
module riscv_muldiv_decode
    import riscv_muldiv_issue_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic       is_mop,
    output logic       is_div,
    output logic       signed_a,
    output logic       signed_b
);

    assign is_mop = (opcode == OPC_OP) && (funct7 == F7_MULDIV);
    // DIV/DIVU/REM/REMU all share funct3[2]
    assign is_div = funct3[2];

    always_comb begin
        signed_a = 1'b0;
        signed_b = 1'b0;
        case (funct3)
            F3_MULH, F3_DIV, F3_REM: begin
                signed_a = 1'b1;
                signed_b = 1'b1;
            end
            F3_MULHSU: begin
                signed_a = 1'b1;
                signed_b = 1'b0;
            end
            F3_MUL, F3_MULHU, F3_DIVU, F3_REMU: begin
                signed_a = 1'b0;
                signed_b = 1'b0;
            end
            default: begin
                signed_a = 1'b0;
                signed_b = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/riscv_muldiv_issue_ctrl.sv
// Issue/sequencing controller for an iterative RV32M multiply/divide datapath with RAW hazard check.
// Accept -> response in 33 cycles (2 on divide by zero); one op in flight, req_rdy low until the response is taken.
module riscv_muldiv_issue_ctrl
    import riscv_muldiv_issue_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_val,
    output logic        req_rdy,
    input  logic [31:0] req_inst,
    input  logic        flush,
    input  logic        dp_divisor_zero,
    output logic        dp_load,
    output logic        dp_step,
    output logic [2:0]  dp_fn,
    output logic        dp_signed_a,
    output logic        dp_signed_b,
    output logic        resp_val,
    input  logic        resp_rdy,
    output logic [4:0]  resp_rd,
    output logic        illegal,
    output logic        busy,
    input  logic [4:0]  chk_rs1,
    input  logic [4:0]  chk_rs2,
    output logic        chk_hazard
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       fn_q;
    logic [4:0]       rd_q;
    logic             sa_q, sb_q, div_q;

    logic is_mop, is_div, signed_a, signed_b;
    logic fire, mop_fire, div_zero_exit;
    logic unused_inst_bits;

    riscv_muldiv_decode u_decode (
        .opcode   (req_inst[6:0]),
        .funct3   (req_inst[14:12]),
        .funct7   (req_inst[31:25]),
        .is_mop   (is_mop),
        .is_div   (is_div),
        .signed_a (signed_a),
        .signed_b (signed_b)
    );

    // Source register fields are the hazard unit's business, not ours
    assign unused_inst_bits = ^req_inst[24:15];

    // Gating with reset_n keeps req_rdy low for the whole reset window
    assign req_rdy  = reset_n && (state_q == ST_IDLE) && !flush;
    assign fire     = req_val && req_rdy;
    assign mop_fire = fire && is_mop;
    assign dp_load  = mop_fire;
    assign illegal  = fire && !is_mop;

    assign busy        = (state_q != ST_IDLE);
    assign resp_val    = (state_q == ST_DONE) && !flush;
    assign resp_rd     = rd_q;
    assign dp_fn       = fn_q;
    assign dp_signed_a = sa_q;
    assign dp_signed_b = sb_q;
    assign chk_hazard  = busy && (rd_q != 5'd0) && ((chk_rs1 == rd_q) || (chk_rs2 == rd_q));

    // A zero divisor is known before the first iteration, so skip straight to DONE
    assign div_zero_exit = (state_q == ST_CALC) && div_q && dp_divisor_zero && (cnt_q == '0);
    assign dp_step       = (state_q == ST_CALC) && !div_zero_exit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mop_fire) begin
                        state_d = ST_CALC;
                        cnt_d   = '0;
                    end
                end
                ST_CALC: begin
                    if (div_zero_exit) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == LAST_STEP) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (resp_rdy) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fn_q  <= 3'd0;
            rd_q  <= 5'd0;
            sa_q  <= 1'b0;
            sb_q  <= 1'b0;
            div_q <= 1'b0;
        end else if (mop_fire) begin
            fn_q  <= req_inst[14:12];
            rd_q  <= req_inst[11:7];
            sa_q  <= signed_a;
            sb_q  <= signed_b;
            div_q <= is_div;
        end
    end

endmodule

// File: tb/tb_riscv_muldiv_issue_ctrl.sv
// Bench for riscv_muldiv_issue_ctrl: per-cycle reference model, op table, directed corner sequences, random traffic.
module tb_riscv_muldiv_issue_ctrl;

    logic        clk;
    logic        reset_n;
    logic        req_val;
    logic        req_rdy;
    logic [31:0] req_inst;
    logic        flush;
    logic        dp_divisor_zero;
    logic        dp_load;
    logic        dp_step;
    logic [2:0]  dp_fn;
    logic        dp_signed_a;
    logic        dp_signed_b;
    logic        resp_val;
    logic        resp_rdy;
    logic [4:0]  resp_rd;
    logic        illegal;
    logic        busy;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic        chk_hazard;

    riscv_muldiv_issue_ctrl dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req_val         (req_val),
        .req_rdy         (req_rdy),
        .req_inst        (req_inst),
        .flush           (flush),
        .dp_divisor_zero (dp_divisor_zero),
        .dp_load         (dp_load),
        .dp_step         (dp_step),
        .dp_fn           (dp_fn),
        .dp_signed_a     (dp_signed_a),
        .dp_signed_b     (dp_signed_b),
        .resp_val        (resp_val),
        .resp_rdy        (resp_rdy),
        .resp_rd         (resp_rd),
        .illegal         (illegal),
        .busy            (busy),
        .chk_rs1         (chk_rs1),
        .chk_rs2         (chk_rs2),
        .chk_hazard      (chk_hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: one op in flight, tracked by when it was accepted and when it must respond
    bit         m_busy    = 1'b0;
    int         m_fire_at = 0;
    int         m_done_at = 0;
    int         cyc       = 0;
    logic [4:0] m_rd      = 5'd0;
    logic [2:0] m_fn      = 3'd0;

    logic s_rdy, s_load, s_ill, s_rv, s_busy, s_haz, s_sa, s_sb, s_step;
    logic [4:0] s_rd;
    logic [2:0] s_fn;

    typedef struct {
        logic [31:0] inst;
        bit          dz;
        int          lat;
        int          rd;
        bit          sa;
        bit          sb;
        bit          ill;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        logic [31:0] w;
        w = {7'b0000001, rs2, rs1, f3, rd, 7'b0110011};
        return w;
    endfunction

    // Samples and checks mid-cycle, then advances the model across the rising edge
    task automatic cycle();
        logic e_rdy, e_load, e_ill, e_step, e_rv, e_busy, e_haz, e_sa, e_sb;
        logic done_now, first_calc, mop, dz_exit;
        logic [4:0] e_rd;
        logic [2:0] e_fn;
        @(negedge clk);
        mop        = (req_inst[6:0] == 7'h33) && (req_inst[31:25] == 7'h01);
        done_now   = m_busy && (cyc >= m_done_at);
        first_calc = m_busy && (cyc == m_fire_at + 1);
        dz_exit    = first_calc && m_fn[2] && dp_divisor_zero;
        if (!reset_n) begin
            e_rdy = 0; e_load = 0; e_ill = 0; e_step = 0; e_rv = 0;
            e_busy = 0; e_haz = 0; e_sa = 0; e_sb = 0; e_rd = 0; e_fn = 0;
        end else begin
            e_rdy  = !m_busy && !flush;
            e_load = e_rdy && req_val && mop;
            e_ill  = e_rdy && req_val && !mop;
            e_step = m_busy && !done_now && !dz_exit;
            e_rv   = done_now && !flush;
            e_busy = m_busy;
            e_haz  = m_busy && (m_rd != 0) && ((chk_rs1 == m_rd) || (chk_rs2 == m_rd));
            e_sa   = (m_fn == 3'd1) || (m_fn == 3'd2) || (m_fn == 3'd4) || (m_fn == 3'd6);
            e_sb   = (m_fn == 3'd1) || (m_fn == 3'd4) || (m_fn == 3'd6);
            e_rd   = m_rd;
            e_fn   = m_fn;
        end
        s_rdy = req_rdy; s_load = dp_load; s_ill = illegal; s_rv = resp_val;
        s_busy = busy; s_haz = chk_hazard; s_sa = dp_signed_a; s_sb = dp_signed_b;
        s_step = dp_step; s_rd = resp_rd; s_fn = dp_fn;
        chk("req_rdy",     int'(s_rdy),  int'(e_rdy));
        chk("dp_load",     int'(s_load), int'(e_load));
        chk("illegal",     int'(s_ill),  int'(e_ill));
        chk("dp_step",     int'(s_step), int'(e_step));
        chk("resp_val",    int'(s_rv),   int'(e_rv));
        chk("busy",        int'(s_busy), int'(e_busy));
        chk("chk_hazard",  int'(s_haz),  int'(e_haz));
        chk("dp_signed_a", int'(s_sa),   int'(e_sa));
        chk("dp_signed_b", int'(s_sb),   int'(e_sb));
        chk("resp_rd",     int'(s_rd),   int'(e_rd));
        chk("dp_fn",       int'(s_fn),   int'(e_fn));
        @(posedge clk);
        if (!reset_n) begin
            m_busy = 0; m_rd = 0; m_fn = 0;
        end else if (flush) begin
            m_busy = 0;
        end else if (e_rv && resp_rdy) begin
            m_busy = 0;
        end else if (e_load) begin
            m_busy = 1; m_fire_at = cyc; m_done_at = cyc + 33;
            m_rd = req_inst[11:7]; m_fn = req_inst[14:12];
        end else if (dz_exit) begin
            m_done_at = cyc + 1;
        end
        cyc++;
        #1;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int lat;
        v = tbl[idx];
        req_val = 1; req_inst = v.inst; dp_divisor_zero = v.dz; resp_rdy = 1;
        cycle();
        chk($sformatf("tbl%0d_illegal", idx), int'(s_ill), int'(v.ill));
        chk($sformatf("tbl%0d_load", idx), int'(s_load), int'(!v.ill));
        req_val = 0;
        lat = -1;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            cycle();
            if (k == 1 && !v.ill) begin
                chk($sformatf("tbl%0d_signed_a", idx), int'(s_sa), int'(v.sa));
                chk($sformatf("tbl%0d_signed_b", idx), int'(s_sb), int'(v.sb));
            end
            if (k == 1 && v.ill) chk($sformatf("tbl%0d_busy", idx), int'(s_busy), 0);
            if (s_rv) begin
                lat = k;
                chk($sformatf("tbl%0d_resp_rd", idx), int'(s_rd), v.rd);
            end
        end
        chk($sformatf("tbl%0d_latency", idx), lat, v.lat);
        if (lat > 0) begin
            cycle();
            chk($sformatf("tbl%0d_idle_after", idx), int'(s_busy), 0);
        end
    endtask

    initial begin
        int lat;
        reset_n = 1; req_val = 0; req_inst = 0; flush = 0; dp_divisor_zero = 0;
        resp_rdy = 1; chk_rs1 = 0; chk_rs2 = 0;
        #2 reset_n = 0;
        cycle();
        chk("rst_req_rdy", int'(s_rdy), 0);
        chk("rst_busy", int'(s_busy), 0);
        cycle();
        reset_n = 1;
        cycle();
        chk("post_rst_req_rdy", int'(s_rdy), 1);

        tbl[0]  = '{32'h027302B3,          1'b0, 33,  5, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{mk(3'd1, 5'd1, 5'd2, 5'd3), 1'b0, 33,  1, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{mk(3'd2, 5'd2, 5'd2, 5'd3), 1'b0, 33,  2, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{mk(3'd3, 5'd3, 5'd2, 5'd3), 1'b0, 33,  3, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{32'h02C5C533,          1'b1,  2, 10, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{mk(3'd5, 5'd7, 5'd2, 5'd3), 1'b1,  2,  7, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{mk(3'd6, 5'd8, 5'd2, 5'd3), 1'b0, 33,  8, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{mk(3'd7, 5'd9, 5'd2, 5'd3), 1'b1,  2,  9, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{mk(3'd0, 5'd11, 5'd2, 5'd3), 1'b1, 33, 11, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{32'h00300233,          1'b0, -1,  0, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{32'h40300233,          1'b0, -1,  0, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{32'h027302BB,          1'b0, -1,  0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 12; i++) run_vec(i);
        dp_divisor_zero = 0;

        // Flush ten cycles after accept, then immediate re-accept
        req_val = 1; req_inst = 32'h027302B3;
        cycle();
        req_val = 0;
        for (int k = 1; k <= 9; k++) cycle();
        flush = 1;
        cycle();
        chk("flush_resp_val", int'(s_rv), 0);
        flush = 0; req_val = 1;
        cycle();
        chk("flush_reaccept_rdy", int'(s_rdy), 1);
        chk("flush_reaccept_load", int'(s_load), 1);
        req_val = 0;
        lat = -1;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            cycle();
            if (s_rv) lat = k;
        end
        chk("reaccept_latency", lat, 33);
        cycle();

        // Hazard against rd=5, then an rd=0 op
        req_val = 1; req_inst = 32'h027302B3;
        cycle();
        req_val = 0; chk_rs1 = 0; chk_rs2 = 5;
        cycle();
        chk("haz_rs2_match", int'(s_haz), 1);
        chk_rs1 = 6; chk_rs2 = 6;
        cycle();
        chk("haz_no_match", int'(s_haz), 0);
        chk_rs1 = 5; chk_rs2 = 0;
        cycle();
        chk("haz_rs1_match", int'(s_haz), 1);
        chk_rs1 = 0;
        for (int k = 0; k < 32; k++) cycle();
        req_val = 1; req_inst = mk(3'd0, 5'd0, 5'd0, 5'd0);
        cycle();
        req_val = 0;
        cycle();
        chk("haz_rd0", int'(s_haz), 0);
        for (int k = 0; k < 33; k++) cycle();

        // Backpressure in DONE, then reset mid-response
        req_val = 1; req_inst = 32'h02C5C533; dp_divisor_zero = 1;
        cycle();
        req_val = 0;
        cycle();
        resp_rdy = 0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("bp_resp_val", int'(s_rv), 1);
            chk("bp_resp_rd", int'(s_rd), 10);
            chk("bp_dp_fn", int'(s_fn), 4);
            chk("bp_req_rdy", int'(s_rdy), 0);
        end
        reset_n = 0;
        cycle();
        chk("rst_mid_resp_val", int'(s_rv), 0);
        chk("rst_mid_busy", int'(s_busy), 0);
        chk("rst_mid_resp_rd", int'(s_rd), 0);
        chk("rst_mid_dp_fn", int'(s_fn), 0);
        reset_n = 1; resp_rdy = 1; dp_divisor_zero = 0;
        cycle();

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            req_val = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) != 0)
                req_inst = mk(3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            else
                req_inst = $urandom;
            flush           = ($urandom_range(0, 99) < 3);
            dp_divisor_zero = ($urandom_range(0, 9) < 3);
            resp_rdy        = ($urandom_range(0, 9) < 6);
            chk_rs1         = 5'($urandom_range(0, 7));
            chk_rs2         = 5'($urandom_range(0, 7));
            reset_n         = ($urandom_range(0, 299) != 0);
            cycle();
        end
        reset_n = 1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
